// File: rtl/add128_seq.sv
// Wide add sequencer: feeds 32-bit slices to an external registered adder and chains the carries.
// Optional signed-overflow output is enabled with `define ADD128_SEQ_OVF_EN.
module add128_seq #(
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  ci,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   s,
    output logic                  co,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_ci,
    input  logic [31:0]           add_s,
    input  logic                  add_co
`ifdef ADD128_SEQ_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORDS-1:0][31:0] a_q, a_d;
    logic [WORDS-1:0][31:0] b_q, b_d;
    logic [WORDS-1:0][31:0] s_q, s_d;
    logic                   carry_q, carry_d;
    logic                   co_q, co_d;
`ifdef ADD128_SEQ_OVF_EN
    logic                   ovf_q, ovf_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
`ifdef ADD128_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        add_a   = '0;
        add_b   = '0;
        add_ci  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    idx_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
`ifdef ADD128_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_a   = a_q[idx_q];
                add_b   = b_q[idx_q];
                add_ci  = carry_q;
                cnt_d   = CNT_W'(ADD_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Adder inputs stay put until the registered result has settled.
                add_a  = a_q[idx_q];
                add_b  = b_q[idx_q];
                add_ci = carry_q;
                if (cnt_q == CNT_W'(1)) begin
                    s_d[idx_q] = add_s;
                    carry_d    = add_co;
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        co_d    = add_co;
`ifdef ADD128_SEQ_OVF_EN
                        ovf_d   = (a_q[WORDS-1][31] == b_q[WORDS-1][31]) &&
                                  (add_s[31] != a_q[WORDS-1][31]);
`endif
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
`ifdef ADD128_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
`ifdef ADD128_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign co   = co_q;
`ifdef ADD128_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_add128_seq.sv
// Scoreboard bench for add128_seq with a two-stage registered 32-bit adder model.
module tb_add128_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] a, b;
    logic         ci;
    logic         busy, done, co;
    logic [127:0] s;
    logic [31:0]  add_a, add_b, add_s;
    logic         add_ci, add_co;
`ifdef ADD128_SEQ_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    add128_seq #(.WORDS(4), .ADD_LAT(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .busy   (busy),
        .done   (done),
        .s      (s),
        .co     (co),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
`ifdef ADD128_SEQ_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Registered adder with two cycles from input sampling to stable output.
    logic [32:0] p1, p2;
    always @(posedge clk) begin
        p1 <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};
        p2 <= p1;
    end
    assign add_s  = p2[31:0];
    assign add_co = p2[32];

    typedef struct packed {
        logic [127:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    int   exp_dones = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                check("sum", s, e.s);
                check("carry_out", {127'd0, co}, {127'd0, e.co});
`ifdef ADD128_SEQ_OVF_EN
                check("overflow", {127'd0, ovf}, {127'd0, e.ovf});
`endif
            end
        end
    end

    task automatic run_op(input logic [127:0] ta, input logic [127:0] tbv, input logic tci,
                          input logic [127:0] exp_s, input logic exp_co, input logic exp_ovf,
                          input logic [3:0] exp_cin, input int inject_at);
        int n;
        int busy_cnt;
        bit got;
        sb.push_back('{s: exp_s, co: exp_co, ovf: exp_ovf});
        exp_dones++;
        @(negedge clk);
        a = ta; b = tbv; ci = tci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("cleared_s_on_accept", s, 128'd0);
        check("cleared_co_on_accept", {127'd0, co}, 128'd0);
        n = 0; busy_cnt = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == inject_at) begin
                a = '1; b = '1; start = 1'b1;
            end else if (n == inject_at + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (n == 1) check("first_add_a", {96'd0, add_a}, {96'd0, ta[31:0]});
            if (n == 1 || n == 4 || n == 7 || n == 10)
                check($sformatf("add_ci_issue%0d", (n - 1) / 3), {127'd0, add_ci},
                      {127'd0, exp_cin[(n - 1) / 3]});
            if (done) got = 1'b1;
        end
        check("done_latency", n, got ? 128'd13 : 128'd999);
        check("busy_cycles", busy_cnt, 128'd12);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_s", s, 128'd0);
        check("rst_co", {127'd0, co}, 128'd0);
        check("rst_add_a", {96'd0, add_a}, 128'd0);
        check("rst_add_ci", {127'd0, add_ci}, 128'd0);
        reset = 1'b0;

        // Carry ripples through every word.
        run_op('1, 128'd0, 1'b1, 128'd0, 1'b1, 1'b0, 4'b1111, -10);
        // Simple add.
        run_op(128'd1, 128'd2, 1'b0, 128'd3, 1'b0, 1'b0, 4'b0000, -10);
        // Start while busy must be ignored.
        run_op(128'd5, 128'd7, 1'b0, 128'd12, 1'b0, 1'b0, 4'b0000, 4);

        // Reset during the WAIT of word 2.
        @(negedge clk);
        a = 128'h1_00000001_00000001; b = 128'h1_00000001_00000001; ci = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("partial_sum", s, 128'h2_00000002);
        reset = 1'b1;
        #1;
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {127'd0, done}, 128'd0);
        check("abort_s", s, 128'd0);
        check("abort_co", {127'd0, co}, 128'd0);
        check("abort_add_a", {96'd0, add_a}, 128'd0);
        check("abort_add_b", {96'd0, add_b}, 128'd0);
        check("abort_add_ci", {127'd0, add_ci}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(128'h1_00000000, 128'h1_00000000, 1'b0, 128'h2_00000000, 1'b0, 1'b0, 4'b0000, -10);

        // Back-to-back: accepted in the cycle after done; previous sum must clear.
        run_op(128'hFFFFFFFF, 128'd1, 1'b0, 128'h1_00000000, 1'b0, 1'b0, 4'b0010, -10);

        // Signed overflow vectors (sum and carry checked in every build).
        run_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, {1'b1, 127'd0}, 1'b0, 1'b1, 4'b1110, -10);
        run_op('1, '1, 1'b0, {{127{1'b1}}, 1'b0}, 1'b1, 1'b0, 4'b1110, -10);

        repeat (4) @(negedge clk);
        check("results_outstanding", sb.size(), 128'd0);
        check("done_pulses", done_cnt, exp_dones);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
